// File: rtl/sdram_rd_burst.sv
// rtl/sdram_rd_burst.sv - SDRAM segment read engine: ACT/READ/PRE sequencing with read-FIFO capture
// Optional SDRAM_RD_PINGPONG_EN: bank_addr toggles between 0 and 1 at every frame_done.
module sdram_rd_burst #(
    parameter int DQ_W      = 16,
    parameter int ROW_W     = 13,
    parameter int COL_W     = 9,
    parameter int BURST_LEN = 4,
    parameter int CAS_LAT   = 3,
    parameter int T_RCD     = 3,
    parameter int T_RP      = 3,
    parameter int SEG_LEN   = 256,
    parameter int ROW_LAST  = 1440
) (
    input  logic             sclk,
    input  logic             s_rst_n,
    input  logic             rd_trig,
    input  logic             rd_en,
    input  logic             ref_req,
    input  logic             rfifo_afull,
    input  logic [DQ_W-1:0]  sdram_dq,
    output logic             rd_req,
    output logic             flag_rd_end,
    output logic             rd_busy,
    output logic             frame_done,
    output logic [3:0]       rd_cmd,
    output logic [ROW_W-1:0] rd_addr,
    output logic [1:0]       bank_addr,
    output logic             rfifo_wr_en,
    output logic [DQ_W-1:0]  rfifo_wr_data
);
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_PRE = 4'b0010;

    localparam int CNT_MAX = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BC_W    = $clog2(BURST_LEN) + 1;
    localparam int WIN_W   = $clog2(BURST_LEN + 1);
    localparam int REM_W   = $clog2(SEG_LEN + 1);

    localparam logic [CNT_W-1:0] RCD_LAST = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(T_RP - 1);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BURST_LEN - 1);
    localparam logic [COL_W-1:0] COL_STEP = COL_W'(BURST_LEN);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'((2 ** COL_W) - BURST_LEN);
    localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(ROW_LAST);
    localparam logic [ROW_W-1:0] A10_ALL  = ROW_W'(1 << 10);
    localparam logic [REM_W-1:0] REM_SEG  = REM_W'(SEG_LEN);
    localparam logic [REM_W-1:0] REM_STEP = REM_W'(BURST_LEN);
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(BURST_LEN);

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_REQ  = 5'b00010,
        S_ACT  = 5'b00100,
        S_RD   = 5'b01000,
        S_PRE  = 5'b10000
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BC_W-1:0]    bcnt_q, bcnt_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic               row_end_q, row_end_d;
    logic [1:0]         bank_q, bank_d;
    logic               armed_q, armed_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [CAS_LAT-1:0] vld_sr_q, vld_sr_d;

    logic               rd_req_q, rd_req_d;
    logic               flag_rd_end_q, flag_rd_end_d;
    logic               rd_busy_q, rd_busy_d;
    logic               frame_done_q, frame_done_d;
    logic [3:0]         rd_cmd_q, rd_cmd_d;
    logic [ROW_W-1:0]   rd_addr_q, rd_addr_d;
    logic [1:0]         bank_addr_q, bank_addr_d;
    logic               rfifo_wr_en_q, rfifo_wr_en_d;
    logic [DQ_W-1:0]    rfifo_wr_data_q, rfifo_wr_data_d;

    logic               boundary;
    logic               rd_issue;
    logic               frame_hit;
    logic               release_bus;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            bcnt_q          <= '0;
            row_q           <= '0;
            col_q           <= '0;
            rem_q           <= '0;
            row_end_q       <= 1'b0;
            bank_q          <= '0;
            armed_q         <= 1'b0;
            win_cnt_q       <= '0;
            vld_sr_q        <= '0;
            rd_req_q        <= 1'b0;
            flag_rd_end_q   <= 1'b0;
            rd_busy_q       <= 1'b0;
            frame_done_q    <= 1'b0;
            rd_cmd_q        <= CMD_NOP;
            rd_addr_q       <= '0;
            bank_addr_q     <= '0;
            rfifo_wr_en_q   <= 1'b0;
            rfifo_wr_data_q <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            bcnt_q          <= bcnt_d;
            row_q           <= row_d;
            col_q           <= col_d;
            rem_q           <= rem_d;
            row_end_q       <= row_end_d;
            bank_q          <= bank_d;
            armed_q         <= armed_d;
            win_cnt_q       <= win_cnt_d;
            vld_sr_q        <= vld_sr_d;
            rd_req_q        <= rd_req_d;
            flag_rd_end_q   <= flag_rd_end_d;
            rd_busy_q       <= rd_busy_d;
            frame_done_q    <= frame_done_d;
            rd_cmd_q        <= rd_cmd_d;
            rd_addr_q       <= rd_addr_d;
            bank_addr_q     <= bank_addr_d;
            rfifo_wr_en_q   <= rfifo_wr_en_d;
            rfifo_wr_data_q <= rfifo_wr_data_d;
        end
    end

    // A boundary is the cycle that decides what the next cycle shows: READ, hold, or PRE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bcnt_d      = bcnt_q;
        row_d       = row_q;
        col_d       = col_q;
        rem_d       = rem_q;
        row_end_d   = row_end_q;
        bank_d      = bank_q;
        armed_d     = 1'b1;
        rd_issue    = 1'b0;
        frame_hit   = 1'b0;
        release_bus = 1'b0;
        boundary    = ((state_q == S_ACT) && (cnt_q == RCD_LAST)) ||
                      ((state_q == S_RD) && (bcnt_q == BC_LAST));

        unique case (state_q)
            S_IDLE: begin
                if (rd_trig && armed_q) begin
                    state_d = S_REQ;
                    rem_d   = REM_SEG;
                end
            end
            S_REQ: begin
                if (rd_en) begin
                    state_d   = S_ACT;
                    cnt_d     = '0;
                    row_end_d = 1'b0;
                end
            end
            S_ACT: cnt_d = cnt_q + 1'b1;
            S_RD:  bcnt_d = bcnt_q + 1'b1;
            S_PRE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RP_LAST) begin
                    if (rem_q != '0 && ref_req) begin
                        state_d     = S_REQ;
                        release_bus = 1'b1;
                    end else if (rem_q != '0) begin
                        state_d   = S_ACT;
                        cnt_d     = '0;
                        row_end_d = 1'b0;
                    end else begin
                        state_d     = S_IDLE;
                        release_bus = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (boundary) begin
            if (rem_q == '0 || row_end_q || ref_req) begin
                state_d = S_PRE;
                cnt_d   = '0;
            end else if (rfifo_afull) begin
                state_d = S_RD;
                bcnt_d  = BC_LAST;
            end else begin
                state_d  = S_RD;
                bcnt_d   = '0;
                rd_issue = 1'b1;
            end
        end

        if (rd_issue) begin
            rem_d = rem_q - REM_STEP;
            col_d = col_q + COL_STEP;
            if (col_q == COL_LAST) begin
                row_end_d = 1'b1;
                if (row_q == ROW_END) begin
                    row_d     = '0;
                    frame_hit = 1'b1;
`ifdef SDRAM_RD_PINGPONG_EN
                    bank_d    = {1'b0, ~bank_q[0]};
`endif
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
        end
    end

    // Outputs are registered from next-state values so each command lines up with its state cycle.
    always_comb begin
        rd_cmd_d  = CMD_NOP;
        rd_addr_d = '0;
        if (state_d == S_ACT && cnt_d == '0) begin
            rd_cmd_d  = CMD_ACT;
            rd_addr_d = row_q;
        end else if (rd_issue) begin
            rd_cmd_d  = CMD_RD;
            rd_addr_d = ROW_W'(col_q);
        end else if (state_d == S_PRE && cnt_d == '0) begin
            rd_cmd_d  = CMD_PRE;
            rd_addr_d = A10_ALL;
        end
        rd_req_d        = (state_d == S_REQ);
        rd_busy_d       = (state_d != S_IDLE);
        flag_rd_end_d   = release_bus;
        frame_done_d    = frame_hit;
        bank_addr_d     = bank_q;
        win_cnt_d       = rd_issue ? WIN_LOAD : ((win_cnt_q != '0) ? win_cnt_q - 1'b1 : '0);
        vld_sr_d        = {vld_sr_q[CAS_LAT-2:0], (win_cnt_q != '0)};
        rfifo_wr_en_d   = vld_sr_q[CAS_LAT-1];
        rfifo_wr_data_d = sdram_dq;
    end

    assign rd_req        = rd_req_q;
    assign flag_rd_end   = flag_rd_end_q;
    assign rd_busy       = rd_busy_q;
    assign frame_done    = frame_done_q;
    assign rd_cmd        = rd_cmd_q;
    assign rd_addr       = rd_addr_q;
    assign bank_addr     = bank_addr_q;
    assign rfifo_wr_en   = rfifo_wr_en_q;
    assign rfifo_wr_data = rfifo_wr_data_q;
endmodule

// File: tb/tb_sdram_rd_burst.sv
// tb/tb_sdram_rd_burst.sv - directed bench for sdram_rd_burst (segment, refresh, backpressure, frame, reset, BL8/CL2)
module tb_sdram_rd_burst;
    localparam int DQ_W = 16;
    localparam int ROW_W = 13;
    localparam int COL_W = 9;
    localparam logic [ROW_W-1:0] ROW_LAST_TB = 13'd1;
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_PRE = 4'b0010;
`ifdef SDRAM_RD_PINGPONG_EN
    localparam logic [1:0] EXP_BANK = 2'd1;
`else
    localparam logic [1:0] EXP_BANK = 2'd0;
`endif

    logic sclk = 1'b0;
    logic s_rst_n = 1'b0;
    logic rd_trig = 1'b0, rd_en = 1'b0, ref_req = 1'b0, rfifo_afull = 1'b0;
    logic [DQ_W-1:0] sdram_dq = '0;
    logic rd_req, flag_rd_end, rd_busy, frame_done, rfifo_wr_en;
    logic [3:0] rd_cmd;
    logic [ROW_W-1:0] rd_addr;
    logic [1:0] bank_addr;
    logic [DQ_W-1:0] rfifo_wr_data;

    logic rd_trig_b = 1'b0, rd_en_b = 1'b1, ref_req_b = 1'b0, rfifo_afull_b = 1'b0;
    logic [DQ_W-1:0] sdram_dq_b = '0;
    logic rd_req_b, flag_rd_end_b, rd_busy_b, frame_done_b, rfifo_wr_en_b;
    logic [3:0] rd_cmd_b;
    logic [ROW_W-1:0] rd_addr_b;
    logic [1:0] bank_addr_b;
    logic [DQ_W-1:0] rfifo_wr_data_b;

    always #5 sclk = ~sclk;

    sdram_rd_burst #(.ROW_LAST(1)) dut (
        .sclk(sclk), .s_rst_n(s_rst_n), .rd_trig(rd_trig), .rd_en(rd_en), .ref_req(ref_req),
        .rfifo_afull(rfifo_afull), .sdram_dq(sdram_dq), .rd_req(rd_req), .flag_rd_end(flag_rd_end),
        .rd_busy(rd_busy), .frame_done(frame_done), .rd_cmd(rd_cmd), .rd_addr(rd_addr),
        .bank_addr(bank_addr), .rfifo_wr_en(rfifo_wr_en), .rfifo_wr_data(rfifo_wr_data)
    );

    sdram_rd_burst #(.BURST_LEN(8), .CAS_LAT(2), .SEG_LEN(16)) dut_bl8 (
        .sclk(sclk), .s_rst_n(s_rst_n), .rd_trig(rd_trig_b), .rd_en(rd_en_b), .ref_req(ref_req_b),
        .rfifo_afull(rfifo_afull_b), .sdram_dq(sdram_dq_b), .rd_req(rd_req_b), .flag_rd_end(flag_rd_end_b),
        .rd_busy(rd_busy_b), .frame_done(frame_done_b), .rd_cmd(rd_cmd_b), .rd_addr(rd_addr_b),
        .bank_addr(bank_addr_b), .rfifo_wr_en(rfifo_wr_en_b), .rfifo_wr_data(rfifo_wr_data_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [DQ_W-1:0] word(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
        return {row[6:0], col};
    endfunction

    int cyc = 0;
    int rd_cnt, act_cnt, pre_cnt, end_cnt, wr_cnt, fd_cnt;
    int first_rd_cyc, first_wr_cyc, act_cyc, fd_col;
    logic [COL_W-1:0] rd_cols[$];
    logic [ROW_W-1:0] act_row = '0;
    logic [1:0] act_bank = '0;
    logic [ROW_W-1:0] exp_row = '0;
    logic [COL_W-1:0] exp_col = '0;
    logic [DQ_W-1:0] sched [32];
    int rd_cyc_b[$];
    int wr_cnt_b, first_wr_b;
    logic [DQ_W-1:0] first_data_b;

    // SDRAM data model: drive DQ during cycles n+CL .. n+CL+BL-1 for a READ shown in cycle n
    always @(posedge sclk) begin
        cyc = cyc + 1;
        #1;
        sdram_dq = sched[cyc % 32];
        sdram_dq_b = DQ_W'(cyc);
    end

    always @(negedge sclk) begin
        if (rd_cmd == CMD_ACT) begin
            act_cnt++;
            act_row = rd_addr;
            act_bank = bank_addr;
            act_cyc = cyc;
        end
        if (rd_cmd == CMD_RD) begin
            if (rd_cnt == 0) first_rd_cyc = cyc;
            rd_cnt++;
            rd_cols.push_back(rd_addr[COL_W-1:0]);
            for (int k = 0; k < 4; k++)
                sched[(cyc + 3 + k) % 32] = word(act_row, rd_addr[COL_W-1:0] + COL_W'(k));
        end
        if (rd_cmd == CMD_PRE) pre_cnt++;
        if (flag_rd_end) end_cnt++;
        if (frame_done) begin
            fd_cnt++;
            fd_col = int'(rd_addr);
        end
        if (rfifo_wr_en) begin
            if (wr_cnt == 0) first_wr_cyc = cyc;
            wr_cnt++;
            check("wr_data", 32'(rfifo_wr_data), 32'(word(exp_row, exp_col)));
            exp_col = exp_col + 1'b1;
            if (exp_col == '0) exp_row = (exp_row == ROW_LAST_TB) ? '0 : exp_row + 1'b1;
        end
        if (rd_cmd_b == CMD_RD) rd_cyc_b.push_back(cyc);
        if (rfifo_wr_en_b) begin
            if (wr_cnt_b == 0) begin
                first_wr_b = cyc;
                first_data_b = rfifo_wr_data_b;
            end
            wr_cnt_b++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge sclk);
        #1;
    endtask

    task automatic clear_stats();
        rd_cnt = 0; act_cnt = 0; pre_cnt = 0; end_cnt = 0; wr_cnt = 0; fd_cnt = 0;
        first_rd_cyc = 0; first_wr_cyc = 0; act_cyc = 0; fd_col = -1;
        rd_cols.delete();
    endtask

    task automatic pulse_trig();
        rd_trig = 1'b1;
        step(1);
        rd_trig = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (rd_busy && n < 3000) begin
            step(1);
            n++;
        end
        check(tag, 32'(n < 3000), 32'd1);
        step(8);
    endtask

    task automatic wait_reads(input int target);
        int n = 0;
        while (rd_cnt < target && n < 3000) begin
            step(1);
            n++;
        end
        check("wait_reads", 32'(n < 3000), 32'd1);
    endtask

    function automatic int col_errs(input int base);
        int bad = 0;
        foreach (rd_cols[i]) if (int'(rd_cols[i]) != base + 4 * i) bad++;
        return bad;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 32; i++) sched[i] = '0;
        clear_stats();
        wr_cnt_b = 0;
        step(3);
        check("rst_cmd", 32'(rd_cmd), 32'(CMD_NOP));
        check("rst_req", 32'(rd_req), 0);
        check("rst_busy", 32'(rd_busy), 0);
        check("rst_end", 32'(flag_rd_end), 0);
        check("rst_frame", 32'(frame_done), 0);
        check("rst_addr", 32'(rd_addr), 0);
        check("rst_bank", 32'(bank_addr), 0);
        check("rst_wr_en", 32'(rfifo_wr_en), 0);
        check("rst_wr_data", 32'(rfifo_wr_data), 0);

        s_rst_n = 1'b1;
        rd_trig = 1'b1;
        step(1);
        rd_trig = 1'b0;
        step(3);
        check("trig_at_release", 32'(rd_busy), 0);

        // full segment: row 0, cols 0..252
        rd_en = 1'b1;
        clear_stats();
        pulse_trig();
        wait_idle("seg1_idle");
        check("seg1_reads", rd_cnt, 64);
        check("seg1_cols", col_errs(0), 0);
        check("seg1_act_cnt", act_cnt, 1);
        check("seg1_act_row", 32'(act_row), 0);
        check("seg1_trcd", first_rd_cyc - act_cyc, 3);
        check("seg1_wr_lat", first_wr_cyc - first_rd_cyc, 4);
        check("seg1_words", wr_cnt, 256);
        check("seg1_pre", pre_cnt, 1);
        check("seg1_end", end_cnt, 1);

        // refresh pre-emption after the 10th READ
        clear_stats();
        pulse_trig();
        wait_reads(10);
        ref_req = 1'b1;
        rd_en = 1'b0;
        n = 0;
        while (end_cnt < 1 && n < 100) begin
            step(1);
            n++;
        end
        check("ref_release", end_cnt, 1);
        check("ref_reads_before", rd_cnt, 10);
        ref_req = 1'b0;
        step(2);
        check("ref_req_out", 32'(rd_req), 1);
        rd_en = 1'b1;
        wait_idle("ref_idle");
        check("ref_reads", rd_cnt, 64);
        check("ref_resume_col", 32'(rd_cols[10]), 296);
        check("ref_cols", col_errs(256), 0);
        check("ref_words", wr_cnt, 256);
        check("ref_pre", pre_cnt, 2);
        check("ref_end", end_cnt, 2);
        check("ref_act_cnt", act_cnt, 2);

        // backpressure hold for 20 cycles; row 1 after the column wrap
        clear_stats();
        pulse_trig();
        wait_reads(8);
        rfifo_afull = 1'b1;
        step(20);
        check("hold_reads", rd_cnt, 8);
        check("hold_pre", pre_cnt, 0);
        check("hold_busy", 32'(rd_busy), 1);
        rfifo_afull = 1'b0;
        wait_idle("hold_idle");
        check("hold_total_reads", rd_cnt, 64);
        check("hold_resume_col", 32'(rd_cols[8]), 32);
        check("hold_cols", col_errs(0), 0);
        check("hold_act_row", 32'(act_row), 1);
        check("hold_words", wr_cnt, 256);
        check("hold_pre_total", pre_cnt, 1);

        // last segment of the frame
        clear_stats();
        pulse_trig();
        wait_idle("frame_idle");
        check("frame_pulses", fd_cnt, 1);
        check("frame_col", fd_col, 508);
        check("frame_act_row", 32'(act_row), 1);
        check("frame_words", wr_cnt, 256);

        // next frame starts at row 0
        clear_stats();
        pulse_trig();
        n = 0;
        while (act_cnt < 1 && n < 100) begin
            step(1);
            n++;
        end
        check("next_act_seen", act_cnt, 1);
        check("next_act_row", 32'(act_row), 0);
        check("next_bank", 32'(act_bank), 32'(EXP_BANK));
        wait_idle("next_idle");
        check("next_words", wr_cnt, 256);

        // BL8 / CL2 instance
        rd_trig_b = 1'b1;
        step(1);
        rd_trig_b = 1'b0;
        n = 0;
        while (rd_busy_b && n < 200) begin
            step(1);
            n++;
        end
        check("bl8_idle", 32'(n < 200), 1);
        step(6);
        check("bl8_reads", rd_cyc_b.size(), 2);
        if (rd_cyc_b.size() >= 2) begin
            check("bl8_spacing", rd_cyc_b[1] - rd_cyc_b[0], 8);
            check("bl8_wr_lat", first_wr_b - rd_cyc_b[0], 3);
            check("bl8_first_data", 32'(first_data_b), 32'(DQ_W'(rd_cyc_b[0] + 2)));
        end
        check("bl8_words", wr_cnt_b, 16);

        // reset two cycles after a READ
        clear_stats();
        pulse_trig();
        wait_reads(1);
        step(2);
        s_rst_n = 1'b0;
        wr_cnt = 0;
        #1;
        check("midrst_cmd", 32'(rd_cmd), 32'(CMD_NOP));
        check("midrst_busy", 32'(rd_busy), 0);
        step(10);
        check("midrst_no_wr", wr_cnt, 0);
        exp_row = '0;
        exp_col = '0;
        s_rst_n = 1'b1;
        step(2);
        clear_stats();
        pulse_trig();
        wait_idle("postrst_idle");
        check("postrst_act_row", 32'(act_row), 0);
        check("postrst_first_col", 32'(rd_cols[0]), 0);
        check("postrst_cols", col_errs(0), 0);
        check("postrst_bank", 32'(act_bank), 0);
        check("postrst_words", wr_cnt, 256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sdram_rd_burst.md
# sdram_rd_burst

Parametrised SDRAM read engine, successor to the fixed 16-bit/BL4 read channel. On `rd_trig` it requests the SDRAM bus from the arbiter. Once granted, it reads one segment of `SEG_LEN` words from a persistent row/column pointer using ACT/READ/PRE sequences, and pushes the returned data into the read FIFO. Burst length, CAS latency, tRCD/tRP, frame geometry and FIFO backpressure are configurable; refresh requests pre-empt the segment and resume it afterwards.

## Interface
- `DQ_W`, 16: SDRAM data width.
- `ROW_W`, 13: row/address bus width.
- `COL_W`, 9: column address width.
- `BURST_LEN`, 4: words per READ; must be 1, 2, 4 or 8 and match the mode register.
- `CAS_LAT`, 3: CAS latency in cycles (2 or 3).
- `T_RCD`, 3: cycles from ACT to first READ.
- `T_RP`, 3: cycles from PRE to next command.
- `SEG_LEN`, 256: words per trigger; multiple of `BURST_LEN`, divides `2**COL_W`.
- `ROW_LAST`, 1440: last row of a frame.

Ports:
- `sclk` in 1: clock.
- `s_rst_n` in 1: reset, asynchronous, active-low.
- `rd_trig` in 1: start one segment; pulse; ignored unless IDLE.
- `rd_en` in 1: arbiter grant.
- `ref_req` in 1: refresh pending.
- `rfifo_afull` in 1: read FIFO almost full.
- `sdram_dq` in DQ_W: SDRAM data bus.
- `rd_req` out 1: bus request (high in REQ).
- `flag_rd_end` out 1: one-cycle pulse, bus released.
- `rd_busy` out 1: state != IDLE.
- `frame_done` out 1: one-cycle pulse, last READ of frame issued.
- `rd_cmd` out 4: {CS#,RAS#,CAS#,WE#}; NOP 0111, ACT 0011, RD 0101, PRE 0010.
- `rd_addr` out ROW_W: SDRAM address.
- `bank_addr` out 2: bank.
- `rfifo_wr_en` out 1: FIFO write strobe.
- `rfifo_wr_data` out DQ_W: FIFO write data.

## Operation
- States: IDLE, REQ, ACT, RD, PRE (one-hot). Transitions:
  - IDLE → REQ on `rd_trig`.
  - REQ → ACT on `rd_en`.
  - ACT → RD after T_RCD cycles.
  - RD → PRE at a burst boundary when the segment is complete, the column pointer wraps (row end), or `ref_req` is high.
  - PRE, after T_RP cycles:
    - → REQ if `ref_req` and words remain;
    - → ACT if words remain;
    - → IDLE otherwise.
  - `flag_rd_end` pulses on the PRE exit to REQ or IDLE.
- ACT: first cycle `rd_cmd`=ACT, `rd_addr`=row pointer, then NOP.
- RD: READ issued every BURST_LEN cycles; `rd_addr`=column pointer zero-extended, A10=0; NOP between READs.
- Backpressure: if `rfifo_afull` is high at a burst boundary, no READ is issued and NOPs are held with the row open until it drops. `ref_req` during the hold → PRE.
- PRE: first cycle `rd_cmd`=PRE, `rd_addr`=A10 set (all banks), then NOP.
- Pointer: column += BURST_LEN per READ, modulo 2**COL_W. On wrap, row += 1. The READ of the last column of `ROW_LAST` pulses `frame_done`, and row/column return to 0.
- The pointer and remaining-word count persist across refresh pre-emption; the segment resumes at the next column.
- Reset mid-operation: state IDLE, pointer and bank 0, capture pipeline flushed; no partial burst is written to the FIFO after reset.

## Timing
- All outputs are registered. Reset values:
  - `rd_cmd`=0111; every other output 0.
- `rd_addr` and `bank_addr` are valid in the same cycle as their `rd_cmd`.
- Capture: READ shown on `rd_cmd` in cycle n → `rfifo_wr_en` high and `rfifo_wr_data`=registered `sdram_dq` in cycles n+CAS_LAT+1 … n+CAS_LAT+BURST_LEN.
  - Implemented as a CAS_LAT+1 deep valid shift register.
- Back-to-back READs give a continuous `rfifo_wr_en`.
- PRE is issued no earlier than BURST_LEN cycles after the last READ, so the burst completes.
- `rd_trig` coincident with reset release is ignored.

## Configuration
- `SDRAM_RD_PINGPONG_EN` defined: `bank_addr` toggles between 0 and 1 at every `frame_done` (double-buffered frames).
- Undefined: `bank_addr` is held at 0.

## Test plan
- Defaults, one trigger, `rd_en` held, `rfifo_afull`=0:
  - ACT at row 0, then 64 READs at columns 0, 4 … 252, then PRE.
  - 256 `rfifo_wr_en` cycles, first one 4 cycles after the first READ.
  - `flag_rd_end` pulses once.
- `ref_req` asserted mid-segment after the 10th READ:
  - PRE, then `flag_rd_end`, REQ.
  - After regrant, READs resume at column 40.
  - 256 words total.
- `rfifo_afull` high for 20 cycles mid-segment:
  - No READ and no extra PRE during the hold.
  - Resumes at the next column; data order is intact.
- Pointer preset to row 1440, column 256, two triggers:
  - `frame_done` pulses on the READ at column 508.
  - Next ACT is at row 0.
  - `bank_addr` is 1 with the macro defined, 0 without.
- `BURST_LEN`=8, `CAS_LAT`=2:
  - READs 8 cycles apart.
  - First `rfifo_wr_en` 3 cycles after a READ.
- `s_rst_n` asserted two cycles after a READ:
  - `rd_cmd`=0111 immediately, `rfifo_wr_en` stays 0.
  - Next trigger starts at row 0, column 0.
